uart_rx_fifo: RTL and testbench

//   UART receiver (8N1) with a small show-ahead receive FIFO. Sits directly upstream of the

---
 rtl/uart_rx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small show-ahead FIFO with a valid/ready read port.
// Framing errors and overruns are reported as registered one-cycle pulses.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          rx,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta;
  logic             rx_s;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic stop_sample;
  logic push_req;
  logic push_ok;
  logic pop;

  // Two-flop synchronizer; the line idles high so reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign stop_sample = ena && (state == S_STOP) && (cnt == CNT_LAST);
  assign push_req    = stop_sample && rx_s;
  assign pop         = rd_valid && rd_ready;
  // A simultaneous pop frees the slot the incoming byte needs.
  assign push_ok     = push_req && ((fifo_count != DEPTH_C) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_sample && !rx_s;
      overrun   <= push_req && !push_ok;
      if (!ena) begin
        state   <= S_IDLE;
        cnt     <= '0;
        bit_idx <= '0;
        shift   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_s) state <= S_START;
          end
          S_START: begin
            if (cnt == CNT_MID) begin
              cnt   <= '0;
              state <= rx_s ? S_IDLE : S_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              shift <= {rx_s, shift[7:1]};
              if (bit_idx == 3'd7) state <= S_STOP;
              else bit_idx <= bit_idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx_s ? S_IDLE : S_BREAK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_BREAK: begin
            // A line held low must return high before a new start bit counts.
            cnt <= '0;
            if (rx_s) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push_ok) fifo_count <= fifo_count - 1'b1;
    end
  end

  assign rd_valid = (fifo_count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: byte scoreboard, a table of back-to-back
// frames, and hand-written sequences for framing, glitch, full-FIFO and abort cases.
module tb_uart_rx_fifo;

  localparam int CPB = 16;
  localparam int DEP = 4;
  // Start edge to first rd_valid: 2 sync + 1 detect + 8 half-bit + 9*16 bits.
  localparam int LATENCY = 155;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       rx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .fifo_count(fifo_count), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int both_cnt = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    int         exp_ovr;
  } vec_t;
  vec_t vecs [5];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %s: got 0x%0h", name, act);
    end else begin
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Flag counters and read-side scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: actual 0x%0h required none", rd_data);
        end else begin
          check("sb_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_ready = 1'b1;
    while (rd_valid && n < 50) begin
      tick();
      n++;
    end
    rd_ready = 1'b0;
    tick();
    check("drain_done", {31'h0, rd_valid}, 32'h0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  task automatic clear_flags();
    ferr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  initial begin
    int c0;
    int lat;
    int n;

    vecs[0] = '{8'h01, 1, 0};
    vecs[1] = '{8'h02, 2, 0};
    vecs[2] = '{8'h03, 3, 0};
    vecs[3] = '{8'h04, 4, 0};
    vecs[4] = '{8'h05, 4, 1};

    rst_n = 1'b0; ena = 1'b1; rx = 1'b1; rd_ready = 1'b0;
    repeat (3) tick();
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_rd_data", {24'h0, rd_data}, 32'h0);
    check("rst_count", {29'h0, fifo_count}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single byte, exact latency, then one-cycle pop.
    exp_q.push_back(8'hA5);
    c0  = cyc;
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        n = 0;
        while (!rd_valid && n < 300) begin
          tick();
          n++;
        end
        lat = cyc - c0;
      end
    join
    check("a5_latency", lat, LATENCY);
    check("a5_data", {24'h0, rd_data}, 32'hA5);
    check("a5_count", {29'h0, fifo_count}, 32'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("a5_pop_valid", {31'h0, rd_valid}, 32'h0);
    check("a5_pop_data", {24'h0, rd_data}, 32'h0);

    // Table: five frames with no reader; the fifth overruns.
    for (int i = 0; i < 5; i++) begin
      clear_flags();
      if (vecs[i].exp_ovr == 0) exp_q.push_back(vecs[i].data);
      send_byte(vecs[i].data, 1'b1);
      repeat (4) tick();
      check("tbl_count", {29'h0, fifo_count}, vecs[i].exp_count);
      check("tbl_overrun", ovr_cnt, vecs[i].exp_ovr);
      check("tbl_frame_err", ferr_cnt, 0);
    end
    drain();

    // Framing error followed by a held-low line.
    clear_flags();
    send_byte(8'h3C, 1'b0);
    repeat (40) tick();
    check("fe_pulses", ferr_cnt, 1);
    check("fe_overrun", ovr_cnt, 0);
    check("fe_count_low", {29'h0, fifo_count}, 32'h0);
    rx = 1'b1;
    repeat (160) tick();
    check("fe_count_high", {29'h0, fifo_count}, 32'h0);
    check("fe_pulses_after", ferr_cnt, 1);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    repeat (4) tick();
    check("fe_next_count", {29'h0, fifo_count}, 32'd1);
    drain();

    // Short low glitch on an idle line.
    clear_flags();
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    check("glitch_count", {29'h0, fifo_count}, 32'h0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_ovr", ovr_cnt, 0);

    // Full FIFO, single pop coinciding with the stop-bit sample.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h11 * (i + 1)));
      send_byte(8'(8'h11 * (i + 1)), 1'b1);
    end
    repeat (2) tick();
    check("full_count", {29'h0, fifo_count}, 32'd4);
    clear_flags();
    exp_q.push_back(8'h99);
    c0 = cyc;
    fork
      send_byte(8'h99, 1'b1);
      begin
        while (cyc < c0 + LATENCY - 1) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
      end
    join
    repeat (2) tick();
    check("full_pop_ovr", ovr_cnt, 0);
    check("full_pop_count", {29'h0, fifo_count}, 32'd4);
    drain();

    // Enable dropped during data bit 4.
    clear_flags();
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (85) tick();
        ena = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
      end
    join
    repeat (4) tick();
    check("ena_count", {29'h0, fifo_count}, 32'h0);
    check("ena_flags", ferr_cnt + ovr_cnt, 0);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    repeat (4) tick();
    check("ena_next_count", {29'h0, fifo_count}, 32'd1);
    drain();

    // Reset asserted during data bit 4.
    clear_flags();
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (85) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", {31'h0, rd_valid}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
      end
    join
    repeat (4) tick();
    check("rst_abort_count", {29'h0, fifo_count}, 32'h0);
    check("rst_abort_flags", ferr_cnt + ovr_cnt, 0);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    repeat (4) tick();
    check("rst_next_count", {29'h0, fifo_count}, 32'd1);
    drain();

    check("flags_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
